// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
// Segment codes are active-low, ordered {dp,g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Entry n is the glyph for hex digit n, decimal point dark.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
        return {~dp, SEG_TABLE[nibble][6:0]};
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_encoder.sv
// Combinational hex nibble plus decimal point to active-low segment code.
module seg_hex_encoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = seg_encode(nibble, dp);

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed DIGITS-wide 7-segment scanner with double-buffered loads,
// blanking, leading-zero suppression, PWM dimming and a per-slot guard time.
module seg_display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 100000000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD      = 16,
    parameter int BRIGHT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    input  logic                  load,
    output logic                  updated,
    output logic [DIGITS-1:0]     cathode,
    output logic [7:0]            segmentout
);

    localparam int SLOT   = CLK_HZ / (REFRESH_HZ * DIGITS);
    localparam int SLOT_W = cnt_w(SLOT);
    localparam int IDX_W  = cnt_w(DIGITS);

    if (SLOT <= GUARD + 1 || DIGITS < 1 || DIGITS > 8) begin : g_param_check
        $error("seg_display_scanner: illegal DIGITS/SLOT/GUARD combination");
    end

    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic [4*DIGITS-1:0] act_data_q, act_data_d, stg_data_q, stg_data_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d, stg_dp_q, stg_dp_d;
    logic [DIGITS-1:0]   act_blank_q, act_blank_d, stg_blank_q, stg_blank_d;
    logic                pend_q, pend_d;
    logic                upd_q, upd_d;
    logic [DIGITS-1:0]   cath_q, cath_d;
    logic [7:0]          seg_q, seg_d;

    logic                slot_wrap, frame_end, run, lit;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          cur_nib;
    logic                cur_dp, cur_off;
    logic [7:0]          enc_seg;

    assign slot_wrap = (slot_q == SLOT_W'(SLOT - 1));
    assign frame_end = slot_wrap && (idx_q == IDX_W'(DIGITS - 1));

    always_comb begin
        slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
        idx_d  = idx_q;
        if (slot_wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        pwm_d  = pwm_q + BRIGHT_W'(1);
    end

    // A load coinciding with the frame boundary still lands in staging and
    // stays pending; only the previously staged data is promoted.
    always_comb begin
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        stg_data_d  = stg_data_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        pend_d      = pend_q;
        upd_d       = frame_end && pend_q;
        if (frame_end && pend_q) begin
            act_data_d  = stg_data_q;
            act_dp_d    = stg_dp_q;
            act_blank_d = stg_blank_q;
            pend_d      = 1'b0;
        end
        if (load) begin
            stg_data_d  = data_in;
            stg_dp_d    = dp_in;
            stg_blank_d = blank_in;
            pend_d      = 1'b1;
        end
    end

    // Suppression run walks down from the top digit; digit 0 is always shown.
    always_comb begin
        run  = lz_en;
        supp = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run     = run && (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
            supp[i] = run;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_off = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = act_data_q[4*i +: 4];
                cur_dp  = act_dp_q[i];
                cur_off = act_blank_q[i] | supp[i];
            end
        end
    end

    seg_hex_encoder u_enc (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (enc_seg)
    );

    assign lit = (slot_q >= SLOT_W'(GUARD)) && (pwm_q <= brightness) && !cur_off;

    always_comb begin
        cath_d = '1;
        seg_d  = SEG_OFF;
        if (lit) begin
            cath_d = ~(DIGITS'(1) << idx_q);
            seg_d  = enc_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '1;
            stg_data_q  <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '1;
            pend_q      <= 1'b0;
            upd_q       <= 1'b0;
            cath_q      <= '1;
            seg_q       <= SEG_OFF;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            act_data_q  <= act_data_d;
            act_dp_q    <= act_dp_d;
            act_blank_q <= act_blank_d;
            stg_data_q  <= stg_data_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            pend_q      <= pend_d;
            upd_q       <= upd_d;
            cath_q      <= cath_d;
            seg_q       <= seg_d;
        end
    end

    assign updated    = upd_q;
    assign cathode    = cath_q;
    assign segmentout = seg_q;

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Parametrised multiplexed 7-segment display driver. It is the successor to the fixed 4-digit display top.
- Scans DIGITS hex digits onto one shared segment bus with a one-hot digit select.
- Adds the following features:
  - tear-free double-buffered loads with an update handshake
  - per-digit blanking and decimal points
  - leading-zero suppression
  - PWM brightness
  - ghosting guard time
- Sits between the application logic and the board's segment and digit pins.

Parameters:
- DIGITS, 4, number of digits scanned (legal range 1..8).
- CLK_HZ, 100000000, input clock frequency.
- REFRESH_HZ, 1000, full-frame refresh rate.
- GUARD, 16, clocks per slot with all digits off at the start of each slot.
- BRIGHT_W, 4, brightness control width.
- Derived: SLOT = CLK_HZ/(REFRESH_HZ*DIGITS) clocks per digit. Elaboration fails if SLOT <= GUARD+1 or DIGITS is outside 1..8.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  4*DIGITS  hex nibbles; digit i = data_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  DIGITS  per-digit force-blank, 1 = dark.
- lz_en  in  1  leading-zero suppression enable (level, sampled live).
- brightness  in  BRIGHT_W  duty control (level, sampled live).
- load  in  1  one-cycle strobe; captures data_in, dp_in and blank_in.
- updated  out  1  one-cycle pulse when the captured data becomes displayed.
- cathode  out  DIGITS  digit select, active-low, at most one bit low.
- segmentout  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.

Behaviour:
- Fixed: one clock; reset is asynchronous and active-low.
- Reset values:
  - cathode = all 1s; segmentout = 8'hFF; updated = 0.
  - digit index = 0; slot counter = 0; PWM counter = 0; pending = 0.
  - active and staging data = 0; dp = 0; blank mask = all 1s, so the display stays dark until the first load.
- Reset mid-scan returns immediately to the reset state; no glitch beyond the async clear.
- Slot counter runs 0..SLOT-1 and wraps.
- On wrap, the digit index increments 0..DIGITS-1 and wraps to 0.
- Frame boundary = the cycle where the slot counter wraps and the digit index wraps DIGITS-1 -> 0.
- Load handshake:
  - load=1 captures inputs into staging and sets pending=1.
  - At a frame boundary with pending=1: active <= staging, pending <= 0, and updated pulses on the next cycle.
  - load on the same cycle as the boundary: the old staging transfers (updated pulses), the new data goes into staging, and pending stays 1.
  - Back-to-back loads before a boundary: last one wins; one updated pulse.
- Leading-zero suppression (lz_en=1): starting from digit DIGITS-1 downward, digits in the contiguous run whose active nibble is 0 and dp is 0 are blanked. Digit 0 is never suppressed.
- A digit is lit when all of the following hold:
  - slot counter >= GUARD
  - PWM counter <= brightness
  - the digit is not blanked (blank mask or suppression)
- PWM counter is BRIGHT_W bits, free-running, +1 per clock.
  - brightness = all 1s gives full on.
  - brightness = 0 gives 1/2^BRIGHT_W duty.
- When lit: cathode bit[index] = 0, segmentout = hex code of the nibble, with bit7 = ~dp.
- When not lit: cathode = all 1s and segmentout = 8'hFF.
- Outputs are registered, 1 clock behind the counters.
- Hex codes (bit7 = 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E

Decomposition:
- display_pkg:
  - 16-entry active-low segment constant table
  - SEG_OFF = 8'hFF
  - encode function
  - width helper for the counters
- One sub-module, seg_hex_encoder (combinational nibble+dp -> 8-bit code), reused by other display blocks.
- Scan, PWM, buffering and suppression logic live in seg_display_scanner.

Test Plan:
Bench parameters: CLK_HZ=64000, REFRESH_HZ=250, DIGITS=4, GUARD=4, BRIGHT_W=4, giving SLOT=64.
1. Reset, then no load for one frame -> cathode=4'hF and segmentout=FF throughout. Assert rst_n mid-slot -> outputs are FF and F immediately.
2. load data_in=16'h4321, blank=0, dp=0, brightness=F -> updated pulses once, after the next frame boundary. Digit 0 then shows cathode=4'b1110 and seg=F9 for cycles 4..63 of its slot, followed by A4, B0, 99 on successive digits.
3. lz_en=1, data 16'h0070, dp=0 -> digits 3 and 2 stay dark, digit 1 shows F8, digit 0 shows C0. With data 16'h0000, only digit 0 shows C0. With dp_in[3]=1, digit 3 shows 40.
4. brightness=0 -> within the lit region of each slot, cathode is low for exactly 1 of every 16 clocks. brightness=7 -> low for 8 of 16.
5. load on the exact frame-boundary cycle while pending -> the old staging value is displayed with updated pulsed. The new value is displayed one frame later with a second updated pulse. Three loads inside one frame -> only the last value is shown and one updated pulse occurs.
6. Sweep all 16 nibbles on digit 2 -> segmentout matches the table, cathode=4'b1011, and no cycle has more than one cathode bit low.
